// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the shared data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 13;
  localparam int unsigned DEF_LINE_W  = 64;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

  typedef enum logic {OP_RD, OP_WR} op_t;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle between the two cache controllers, the arbiter and d_mem.
// slave: the arbiter's view; master: the surrounding CPUs and memory.
interface dmem_arb_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LINE_W = 64
);

  // CPU0 side
  logic [ADDR_W-1:0] u_addr_0;
  logic              u_re_0;
  logic              u_we_0;
  logic [LINE_W-1:0] d_line_0;
  logic [LINE_W-1:0] u_rd_data_0;
  logic              u_rdy_0;

  // CPU1 side
  logic [ADDR_W-1:0] u_addr_1;
  logic              u_re_1;
  logic              u_we_1;
  logic [LINE_W-1:0] d_line_1;
  logic [LINE_W-1:0] u_rd_data_1;
  logic              u_rdy_1;

  // d_mem side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rd_data;
  logic              mem_rdy;

  modport slave (
    input  u_addr_0, u_re_0, u_we_0, d_line_0,
    input  u_addr_1, u_re_1, u_we_1, d_line_1,
    input  mem_rd_data, mem_rdy,
    output u_rd_data_0, u_rdy_0, u_rd_data_1, u_rdy_1,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output u_addr_0, u_re_0, u_we_0, d_line_0,
    output u_addr_1, u_re_1, u_we_1, d_line_1,
    output mem_rd_data, mem_rdy,
    input  u_rd_data_0, u_rdy_0, u_rd_data_1, u_rdy_1,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/dmem_arb_rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes
// to the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_id,
  output logic       gnt_vld
);

  // Pick the winner from the request vector and the previous owner
  always_comb begin
    gnt_vld = |req;
    gnt_id  = 1'b0;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arb.sv
// Arbitrates two CPUs' line-fill / write-back requests onto one d_mem port.
// One transaction in flight, round-robin on ties, watchdog on d_mem latency.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic      clk,
  input  logic      rst,
  dmem_arb_if.slave bus,
  output logic      busy,
  output logic      grant_id,
  output logic      timeout_err
);

  // Last BUSY cycle count before the watchdog aborts.
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wd_cnt_q, wd_cnt_d;
  logic [LINE_W-1:0] rd_data_0_q, rd_data_0_d;
  logic [LINE_W-1:0] rd_data_1_q, rd_data_1_d;
  logic              rdy_0_q, rdy_0_d;
  logic              rdy_1_q, rdy_1_d;
  logic              timeout_err_q, timeout_err_d;

  logic              pick_id;
  logic              pick_vld;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_line;
  logic [LINE_W-1:0] rd_val;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.u_re_1 | bus.u_we_1, bus.u_re_0 | bus.u_we_0}),
    .last_grant (last_grant_q),
    .gnt_id     (pick_id),
    .gnt_vld    (pick_vld)
  );

  // Steer the winning requester's address, data and op onto the grant path
  always_comb begin
    sel_we   = pick_id ? bus.u_we_1   : bus.u_we_0;
    sel_addr = pick_id ? bus.u_addr_1 : bus.u_addr_0;
    sel_line = pick_id ? bus.d_line_1 : bus.d_line_0;
  end

  // Next-state logic for the arbiter FSM, watchdog and return path
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wd_cnt_d      = wd_cnt_q;
    rd_data_0_d   = rd_data_0_q;
    rd_data_1_d   = rd_data_1_q;
    rdy_0_d       = 1'b0;
    rdy_1_d       = 1'b0;
    timeout_err_d = 1'b0;
    // Aborted reads return zeros so a stale line is never mistaken for data.
    rd_val        = bus.mem_rdy ? bus.mem_rd_data : '0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d  = BUSY;
          id_d     = pick_id;
          op_d     = sel_we ? OP_WR : OP_RD;  // re+we together: write wins
          addr_d   = sel_addr;
          wdata_d  = sel_line;
          wd_cnt_d = '0;
        end
      end
      BUSY: begin
        wd_cnt_d = wd_cnt_q + 8'd1;
        if (bus.mem_rdy || (wd_cnt_q == WdLast)) begin
          state_d       = DONE;
          last_grant_d  = id_q;
          timeout_err_d = ~bus.mem_rdy;
          if (id_q) rdy_1_d = 1'b1;
          else      rdy_0_d = 1'b1;
          if (op_q == OP_RD) begin
            if (id_q) rd_data_1_d = rd_val;
            else      rd_data_0_d = rd_val;
          end
        end
      end
      // One dead cycle lets the requester drop its level request after u_rdy.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      op_q          <= OP_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      wd_cnt_q      <= '0;
      rd_data_0_q   <= '0;
      rd_data_1_q   <= '0;
      rdy_0_q       <= 1'b0;
      rdy_1_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wd_cnt_q      <= wd_cnt_d;
      rd_data_0_q   <= rd_data_0_d;
      rd_data_1_q   <= rd_data_1_d;
      rdy_0_q       <= rdy_0_d;
      rdy_1_q       <= rdy_1_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.mem_re      = (state_q == BUSY) && (op_q == OP_RD);
  assign bus.mem_we      = (state_q == BUSY) && (op_q == OP_WR);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.u_rd_data_0 = rd_data_0_q;
  assign bus.u_rd_data_1 = rd_data_1_q;
  assign bus.u_rdy_0     = rdy_0_q;
  assign bus.u_rdy_1     = rdy_1_q;
  assign busy            = (state_q != IDLE);
  assign grant_id        = id_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Downstream of the two CPU cache controllers in the SMP top level.
- Arbitrates the two CPUs' line-fill and write-back requests (u_addr/u_re/u_we/d_line) onto the single shared d_mem port.
- Returns read data and a completion strobe (u_rd_data/u_rdy) to the requester.
- One memory transaction outstanding at a time; round-robin fairness; watchdog on d_mem latency.

Parameters:
- ADDR_W, 13, line address width, matching the bus line address.
- LINE_W, 64, cache line width in bits (4 x 16-bit words).
- TIMEOUT, 64, maximum cycles waiting for mem_rdy before abort; legal range 2..255.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- u_addr_0, in, ADDR_W: CPU0 line address; held stable while its request is high.
- u_re_0, in, 1: CPU0 line read request; level, held until u_rdy_0.
- u_we_0, in, 1: CPU0 line write request; level, held until u_rdy_0.
- d_line_0, in, LINE_W: CPU0 write data.
- u_rd_data_0, out, LINE_W: CPU0 read data; valid with u_rdy_0, then held.
- u_rdy_0, out, 1: CPU0 completion; 1-cycle pulse.
- u_addr_1, u_re_1, u_we_1, d_line_1, u_rd_data_1, u_rdy_1: same as CPU0, for CPU1.
- mem_addr, out, ADDR_W: d_mem address.
- mem_re, out, 1: d_mem read strobe; level, held until mem_rdy.
- mem_we, out, 1: d_mem write strobe; level, held until mem_rdy.
- mem_wdata, out, LINE_W: d_mem write data.
- mem_rd_data, in, LINE_W: d_mem read data; valid with mem_rdy.
- mem_rdy, in, 1: d_mem completion; 1-cycle pulse.
- busy, out, 1: high in any state other than IDLE.
- grant_id, out, 1: requester owning the current or last transaction.
- timeout_err, out, 1: 1-cycle pulse when a transaction is aborted.

Behaviour:
- Reset: state=IDLE, last_grant=1 (so CPU0 wins first), and all of these are 0: mem_re, mem_we, mem_addr, mem_wdata, u_rdy_x, u_rd_data_x, busy, grant_id, timeout_err, wd_cnt.
- Reset mid-transaction abandons the d_mem operation. No u_rdy is issued.
- States:
  - IDLE -> BUSY when any request is present.
  - BUSY -> DONE on mem_rdy or on timeout.
  - DONE -> IDLE unconditionally.
- Request from CPUx: req_x = u_re_x | u_we_x.
- Arbitration (IDLE only):
  - If only one req_x is high, grant x.
  - If both are high, grant !last_grant.
  - On grant, latch id, mem_addr, mem_wdata, and op into registers.
  - Op is write if u_we_x is high, else read. u_re_x and u_we_x together are illegal; write wins.
- BUSY:
  - mem_re or mem_we is asserted from the registered op.
  - mem_addr and mem_wdata stay stable.
  - wd_cnt increments every cycle.
- On mem_rdy in BUSY:
  - Deassert the strobe on the next edge.
  - Capture mem_rd_data into u_rd_data_<id>; write ops leave it unchanged.
  - Pulse u_rdy_<id> for one cycle (registered, in DONE).
  - Set last_grant=id and go to DONE.
- Timeout: if wd_cnt reaches TIMEOUT-1 with no mem_rdy:
  - Deassert the strobe and pulse timeout_err together with u_rdy_<id>.
  - u_rd_data_<id> is set to 0 on read; last_grant is updated as normal.
  - Go to DONE.
- DONE: requests are ignored. This gives the requester one cycle to drop its level request after u_rdy and prevents re-granting a stale request.
- Latency:
  - Request first seen high at edge N -> strobe high after edge N+1.
  - mem_rdy at edge K -> u_rdy high after K+1.
  - IDLE after K+2; earliest next strobe after K+3.
- mem_rdy outside BUSY is ignored.
- u_rd_data_x of the non-granted CPU is never modified.
- A requester dropping its request mid-BUSY is illegal. The transaction completes anyway.
- wd_cnt is 8 bits and clears on entry to BUSY.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum arb_state_t {IDLE, BUSY, DONE};
  - op_t {OP_RD, OP_WR};
  - default constants ADDR_W=13, LINE_W=64, TIMEOUT=64.
- Sub-module rr_arb2: 2-input round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_id, gnt_vld.
  - Combinational.
- FSM, watchdog, and datapath registers stay in dmem_arb.

Test Plan:
- Single read: CPU0 u_re_0=1, u_addr_0=0x0A4; d_mem returns 64'h1111_2222_3333_4444 after 5 cycles -> mem_re high for 5 cycles with mem_addr=0x0A4; u_rdy_0 pulses once; u_rd_data_0 matches; u_rd_data_1 stays 0.
- Simultaneous: CPU0 read 0x010 and CPU1 write 0x020 asserted in the same cycle, and both CPUs re-request after each completion -> first grant CPU0, then CPU1, then CPU0 (alternating); mem_wdata=d_line_1 during the CPU1 write.
- Back-to-back: CPU1 holds a request one cycle past u_rdy_1 -> no duplicate grant in DONE; second transaction only if the request is still high in IDLE.
- Timeout: TIMEOUT=8, mem_rdy never asserted -> strobe drops after 8 BUSY cycles; timeout_err and u_rdy pulse together; u_rd_data=0; next request proceeds normally.
- Reset mid-BUSY: rst=1 for one cycle during a CPU1 write -> all outputs 0 on the next edge, no u_rdy_1; a following CPU0 request is granted first.
- Illegal re+we: CPU0 asserts both with addr 0x1FF -> mem_we=1, mem_re=0.
